sc1_input_port: RTL and testbench

Input-side peripheral for the sc1_cpu board top: synchronizes and debounces slide switches and push buttons and presents them on the CPU `port_in` word. It also holds sticky per-key press events that the CPU clears by toggling bits of its `port_out`. It takes the place of the constant-zero `port_in` tie-off and sits between the board pins and `sc1_cpu.port_in`.

---
 rtl/sc1_io_pkg.sv | 14 +
 rtl/sc1_input_port_if.sv | 28 ++
 rtl/sc1_debounce_bit.sv | 39 +++
 rtl/sc1_input_port.sv | 96 +++++++++
 tb/tb_sc1_input_port.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sc1_io_pkg.sv
// sc1 board I/O shared definitions.
// Field offsets of the port_in status word and debounce defaults.
package sc1_io_pkg;

  localparam int SW_LSB      = 0;
  localparam int KEY_LVL_LSB = 10;
  localparam int KEY_EVT_LSB = 14;

  localparam int TICK_CYCLES_DEF  = 500000;
  localparam int STABLE_TICKS_DEF = 3;

  typedef logic [2:0] db_cnt_t;

endpackage

// File: rtl/sc1_input_port_if.sv
// sc1 input port bundle: board pins and ack strobes in,
// registered status word out.
interface sc1_input_port_if #(
  parameter int WIDTH_REG = 32,
  parameter int N_SW      = 10,
  parameter int N_KEY     = 4
);

  logic [N_SW-1:0]      sw;
  logic [N_KEY-1:0]     key_n;
  logic [N_KEY-1:0]     ack;
  logic [WIDTH_REG-1:0] port_in;

  modport master (
    output sw,
    output key_n,
    output ack,
    input  port_in
  );

  modport slave (
    input  sw,
    input  key_n,
    input  ack,
    output port_in
  );

endinterface

// File: rtl/sc1_debounce_bit.sv
// One-bit synchronizer and tick-sampled debouncer.
// stable follows raw only after STABLE_TICKS differing ticks.
module sc1_debounce_bit
  import sc1_io_pkg::*;
#(
  parameter logic INIT         = 1'b0,
  parameter int   STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  logic [1:0] sync;
  db_cnt_t    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= {2{INIT}};
      cnt    <= '0;
      stable <= INIT;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == db_cnt_t'(STABLE_TICKS - 1)) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + db_cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sc1_input_port.sv
// sc1 input port: debounced switches/keys and sticky key
// press events presented on the CPU port_in word.
module sc1_input_port
  import sc1_io_pkg::*;
#(
  parameter int WIDTH_REG    = 32,
  parameter int N_SW         = 10,
  parameter int N_KEY        = 4,
  parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input logic              clk,
  input logic              reset,
  sc1_input_port_if.slave  io
);

  localparam int PW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0]        pre;
  logic                 tick;
  logic [N_SW-1:0]      sw_stb;
  logic [N_KEY-1:0]     key_stb;
  logic [N_KEY-1:0]     key_lvl;
  logic [N_KEY-1:0]     key_lvl_d;
  logic [N_KEY-1:0]     ack_d;
  logic [N_KEY-1:0]     evt;
  logic [N_KEY-1:0]     evt_set;
  logic [N_KEY-1:0]     evt_clr;
  logic [WIDTH_REG-1:0] word;

  assign tick = (pre == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sc1_debounce_bit #(
      .INIT         (1'b0),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .raw    (io.sw[i]),
      .stable (sw_stb[i])
    );
  end

  // Keys debounce in raw active-low sense so reset reads released.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    sc1_debounce_bit #(
      .INIT         (1'b1),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .raw    (io.key_n[i]),
      .stable (key_stb[i])
    );
  end

  assign key_lvl = ~key_stb;
  assign evt_set = key_lvl & ~key_lvl_d;
  assign evt_clr = io.ack & ~ack_d;

  always_comb begin
    word = '0;
    word[SW_LSB +: N_SW]       = sw_stb;
    word[KEY_LVL_LSB +: N_KEY] = key_lvl;
    word[KEY_EVT_LSB +: N_KEY] = evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_lvl_d  <= '0;
      ack_d      <= '0;
      evt        <= '0;
      io.port_in <= '0;
    end else begin
      key_lvl_d  <= key_lvl;
      ack_d      <= io.ack;
      evt        <= evt_set | (evt & ~evt_clr);
      io.port_in <= word;
    end
  end

endmodule

// File: tb/tb_sc1_input_port.sv
// Self-checking bench for sc1_input_port.
// Waited responses go through a scoreboard queue.
module tb_sc1_input_port;
  import sc1_io_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sc1_input_port_if #(
    .WIDTH_REG (32),
    .N_SW      (10),
    .N_KEY     (4)
  ) io ();

  sc1_input_port #(
    .WIDTH_REG    (32),
    .N_SW         (10),
    .N_KEY        (4),
    .TICK_CYCLES  (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  // Edge count since reset release; tick edges are cyc % 4 == 0.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(string tag, logic [31:0] m,
                      logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.mask = m;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic pop_wait(int budget);
    exp_t e;
    int   n;
    e = sbq.pop_front();
    n = 0;
    while (((io.port_in & e.mask) !== e.val) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(e.tag, io.port_in & e.mask, e.val);
  endtask

  task automatic wait_phase();
    @(negedge clk);
    for (int i = 0; i < 4 && (cyc % 4) != 0; i++)
      @(negedge clk);
  endtask

  task automatic wait_cyc(int target);
    for (int i = 0; i < 40 && cyc != target; i++)
      @(negedge clk);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    logic hi;

    io.sw    = 10'h3FF;
    io.key_n = 4'hF;
    io.ack   = 4'h0;
    reset    = 1'b1;
    cycles(3);
    chk("rst_word", io.port_in, 32'h0);
    reset = 1'b0;
    push("rst_sw", 32'h3FF, 32'h3FF);
    pop_wait(19);
    chk("rst_upper", io.port_in & 32'hFFFF_FC00, 32'h0);

    io.sw = '0;
    push("sw_clr", 32'h3FF, 32'h0);
    pop_wait(24);

    // glitch spans 8 edges: exactly two ticks
    io.sw[0] = 1'b1;
    cycles(8);
    io.sw[0] = 1'b0;
    hi = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hi |= io.port_in[0];
    end
    chk("bounce", {31'b0, hi}, 32'h0);

    io.sw[0] = 1'b1;
    push("sw0_steady", 32'h1, 32'h1);
    pop_wait(24);

    io.key_n[1] = 1'b0;
    push("key1_lvl", 32'h800, 32'h800);
    pop_wait(24);
    chk("evt1_lag", {31'b0, io.port_in[15]}, 32'h0);
    @(negedge clk);
    chk("evt1_set", {31'b0, io.port_in[15]}, 32'h1);

    io.key_n[1] = 1'b1;
    push("key1_rel", 32'h800, 32'h0);
    pop_wait(24);
    chk("evt1_sticky", {31'b0, io.port_in[15]}, 32'h1);

    @(negedge clk);
    io.ack[1] = 1'b1;
    @(negedge clk);
    chk("ack_lag", {31'b0, io.port_in[15]}, 32'h1);
    @(negedge clk);
    chk("ack_clr", {31'b0, io.port_in[15]}, 32'h0);

    io.key_n[1] = 1'b0;
    push("key1_lvl2", 32'h800, 32'h800);
    pop_wait(24);
    @(negedge clk);
    chk("evt1_reset", {31'b0, io.port_in[15]}, 32'h1);
    cycles(6);
    chk("evt1_hold", {31'b0, io.port_in[15]}, 32'h1);
    io.key_n[1] = 1'b1;
    io.ack[1]   = 1'b0;
    push("key1_rel2", 32'h800, 32'h0);
    pop_wait(24);

    // stable changes on third tick edge c0+12; event sets at c0+13
    wait_phase();
    c0 = cyc;
    io.key_n[2] = 1'b0;
    wait_cyc(c0 + 12);
    chk("col_pre", {31'b0, io.port_in[12]}, 32'h0);
    io.ack[2] = 1'b1;
    @(negedge clk);
    chk("col_lvl", {31'b0, io.port_in[12]}, 32'h1);
    @(negedge clk);
    chk("col_evt", {31'b0, io.port_in[16]}, 32'h1);
    cycles(4);
    chk("col_hold", {31'b0, io.port_in[16]}, 32'h1);
    io.key_n[2] = 1'b1;
    io.ack[2]   = 1'b0;
    push("key2_rel", 32'h1000, 32'h0);
    pop_wait(24);

    wait_phase();
    c0 = cyc;
    io.sw[3] = 1'b1;
    wait_cyc(c0 + 9);
    reset = 1'b1;
    cycles(2);
    chk("mid_rst_word", io.port_in, 32'h0);
    reset = 1'b0;
    hi = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hi |= io.port_in[3];
    end
    chk("mid_rst_hold", {31'b0, hi}, 32'h0);
    @(negedge clk);
    chk("mid_rst_set", {31'b0, io.port_in[3]}, 32'h1);

    chk("sb_empty", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
